pdl_ram_arbiter: RTL and testbench
==================================

Name: pdl_ram_arbiter

Overview:
Sequencer and arbiter for the 1kx32 PDL scratch RAM. Drives a single port (port A) of the RAM from two requesters: the CPU microcode datapath (primary) and the SPY/debug bus (secondary).
After reset it sweeps all 1024 words to zero, because the RAM array itself has no reset. It then grants one access per cycle using CPU priority with a bounded wait for SPY, and returns read data with fixed one-cycle latency.

Parameters:
STARVE_LIMIT, 4, consecutive denied SPY cycles after which SPY wins the next contention (1..15).
CLEAR_ON_RESET, 1, 1 = run zeroing sweep after reset; 0 = enter RUN directly.

Ports:
clk_a  in  1  clock; RAM port A clock.
reset  in  1  synchronous, active-high.
cpu_req  in  1  CPU access request; held until cpu_gnt.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  10  word address.
cpu_wdata  in  32  write data.
cpu_gnt  out  1  request accepted this cycle (combinational).
cpu_rvalid  out  1  read data valid (registered).
cpu_rdata  out  32  read data; meaningful only when cpu_rvalid.
spy_req, spy_we, spy_addr[9:0], spy_wdata[31:0]  in  same as CPU.
spy_gnt, spy_rvalid, spy_rdata[31:0]  out  same as CPU.
init_busy  out  1  zeroing sweep in progress.
ram_address  out  10  to RAM address_a.
ram_data  out  32  to RAM data_a.
ram_wren  out  1  to RAM wren_a.
ram_rden  out  1  to RAM rden_a.
ram_q  in  32  from RAM q_a; registered inside the RAM, one cycle after rden.

Behaviour:
- States: INIT, RUN.
- Reset values:
  - State = INIT if CLEAR_ON_RESET, else RUN.
  - init_busy = CLEAR_ON_RESET.
  - clr_cnt = 0, spy_wait = 0.
  - cpu_rvalid = spy_rvalid = 0.
  - No gnt and no RAM strobe is asserted during the reset cycle.
- INIT:
  - Each cycle: ram_wren=1, ram_address=clr_cnt, ram_data=0; clr_cnt increments.
  - When clr_cnt==1023 is written, go to RUN and drop init_busy. The sweep takes exactly 1024 cycles.
  - No grants are issued during INIT; requests stay pending.
- RUN arbitration (combinational each cycle):
  - Only cpu_req: CPU granted.
  - Only spy_req: SPY granted.
  - Both requesting: SPY granted iff spy_wait==STARVE_LIMIT, otherwise CPU granted.
  - spy_wait increments (saturating at STARVE_LIMIT) on every cycle with spy_req && !spy_gnt. It clears on spy_gnt or when spy_req is low.
- Granted access:
  - ram_address and ram_data come from the winner.
  - ram_wren = winner.we; ram_rden = !winner.we.
  - With no grant, ram_wren = ram_rden = 0 and ram_address/ram_data are don't-care (drive 0).
- Read return:
  - The winner's rvalid is asserted on the cycle after a read grant; rdata = ram_q (combinational pass-through to both rdata outputs).
  - Writes produce no rvalid.
  - Back-to-back reads, including interleaved CPU/SPY reads, are fully pipelined at one per cycle.
- Hazards:
  - A read granted the cycle after a write to the same address returns the new data; port A is sequential, so no forwarding is needed.
  - Port B of the RAM is outside this block.
- Reset mid-operation:
  - Any in-flight rvalid is dropped (forced 0 next cycle) and the state returns to INIT.
  - A partially completed sweep restarts at 0.

Decomposition:
- Shared package pdl_pkg holds:
  - PDL_AW=10, PDL_DW=32, PDL_DEPTH=1024.
  - Enum arb_state_t {INIT, RUN}.
  - Requester-id encoding (REQ_CPU=0, REQ_SPY=1), used for the rvalid steering register.
- One natural sub-module: pdl_arb_starve, the fixed-priority-with-aging two-way picker holding spy_wait. The sweep counter and the return pipeline stay in the top module.

Test Plan:
- Reset, CLEAR_ON_RESET=1 -> init_busy=1 for exactly 1024 cycles; ram_wren=1 with addresses 0..1023 and data 0; no gnt while cpu_req is held; cpu_gnt is asserted the first cycle after init_busy falls.
- CPU write 0x3FF <- 32'hDEADBEEF, then read 0x3FF -> cpu_gnt each cycle; cpu_rvalid exactly one cycle after the read grant with cpu_rdata=32'hDEADBEEF; spy_rvalid stays 0.
- cpu_req and spy_req held continuously for 20 cycles, STARVE_LIMIT=4 -> CPU wins 4 cycles, then SPY wins 1, repeating; spy_wait never exceeds 4.
- Alternating grants CPU read addr 5 / SPY read addr 6 every cycle -> rvalid toggles between cpu and spy each cycle with the correct data; no bubble cycles.
- Assert reset one cycle after a CPU read grant -> cpu_rvalid stays 0; the sweep restarts at address 0.
- CLEAR_ON_RESET=0 -> init_busy=0 after reset; a spy read is granted on the first cycle after reset.

Source files
------------

// File: rtl/pdl_pkg.sv
// Shared types and constants for the PDL scratch RAM port-A sequencer.
// Geometry, sequencer states and requester ids live here so every PDL block agrees on them.
package pdl_pkg;

    localparam int PDL_AW    = 10;
    localparam int PDL_DW    = 32;
    localparam int PDL_DEPTH = 1024;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    // Identifies which requester owns the read currently returning from the RAM.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_SPY = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              we;
        logic [PDL_AW-1:0] addr;
        logic [PDL_DW-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/pdl_arb_starve.sv
// Two-way picker: CPU has priority, but SPY wins a contention once it has been
// denied STARVE_LIMIT consecutive cycles. Grants are combinational.
module pdl_arb_starve
    import pdl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_a,
    input  logic reset,
    input  logic en_i,
    input  logic cpu_req_i,
    input  logic spy_req_i,
    output logic cpu_gnt_o,
    output logic spy_gnt_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] spy_wait_q;
    logic [3:0] spy_wait_d;
    logic       spy_wins;

    assign spy_wins  = spy_req_i && (!cpu_req_i || (spy_wait_q == LIMIT));
    assign cpu_gnt_o = en_i && cpu_req_i && !spy_wins;
    assign spy_gnt_o = en_i && spy_wins;

    // Ages only while SPY is actually left waiting; any grant or idle cycle restarts it.
    always_comb begin
        spy_wait_d = 4'd0;
        if (spy_req_i && !spy_gnt_o) begin
            spy_wait_d = (spy_wait_q == LIMIT) ? spy_wait_q : spy_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk_a) begin
        if (reset) begin
            spy_wait_q <= 4'd0;
        end else begin
            spy_wait_q <= spy_wait_d;
        end
    end

endmodule

// File: rtl/pdl_ram_arbiter.sv
// Port-A sequencer for the 1kx32 PDL scratch RAM: zeroing sweep after reset, then
// one CPU/SPY access per cycle with one-cycle read return steered to the winner.
module pdl_ram_arbiter
    import pdl_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk_a,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [PDL_AW-1:0] cpu_addr,
    input  logic [PDL_DW-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [PDL_DW-1:0] cpu_rdata,
    input  logic              spy_req,
    input  logic              spy_we,
    input  logic [PDL_AW-1:0] spy_addr,
    input  logic [PDL_DW-1:0] spy_wdata,
    output logic              spy_gnt,
    output logic              spy_rvalid,
    output logic [PDL_DW-1:0] spy_rdata,
    output logic              init_busy,
    output logic [PDL_AW-1:0] ram_address,
    output logic [PDL_DW-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [PDL_DW-1:0] ram_q
);

    localparam arb_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;
    localparam logic [PDL_AW-1:0] LAST_ADDR   = PDL_AW'(PDL_DEPTH - 1);

    arb_state_t        state_q;
    logic [PDL_AW-1:0] clr_cnt_q;
    logic              init_busy_q;
    logic              rd_valid_q;
    logic              rd_valid_d;
    req_id_t           rd_sel_q;
    req_id_t           rd_sel_d;
    logic              arb_en;
    ram_req_t          cpu_r;
    ram_req_t          spy_r;
    ram_req_t          win_r;

    assign arb_en = (state_q == RUN) && !reset;
    assign cpu_r  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign spy_r  = '{we: spy_we, addr: spy_addr, wdata: spy_wdata};

    pdl_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_a     (clk_a),
        .reset     (reset),
        .en_i      (arb_en),
        .cpu_req_i (cpu_req),
        .spy_req_i (spy_req),
        .cpu_gnt_o (cpu_gnt),
        .spy_gnt_o (spy_gnt)
    );

    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q     <= RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= RESET_STATE;
                    init_busy_q <= (CLEAR_ON_RESET != 0);
                end
            endcase
        end
    end

    // The sweep owns the port in INIT; otherwise the winner drives it. Idle cycles drive zeros.
    always_comb begin
        win_r       = cpu_r;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        if (!reset) begin
            if (state_q == INIT) begin
                ram_wren    = 1'b1;
                ram_address = clr_cnt_q;
            end else if (cpu_gnt || spy_gnt) begin
                win_r       = spy_gnt ? spy_r : cpu_r;
                ram_wren    = win_r.we;
                ram_rden    = !win_r.we;
                ram_address = win_r.addr;
                ram_data    = win_r.wdata;
            end
        end
    end

    assign rd_valid_d = (cpu_gnt && !cpu_we) || (spy_gnt && !spy_we);
    assign rd_sel_d   = spy_gnt ? REQ_SPY : REQ_CPU;

    always_ff @(posedge clk_a) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= REQ_CPU;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    // RAM output register already provides the latency; data passes straight through.
    assign cpu_rvalid = rd_valid_q && (rd_sel_q == REQ_CPU) && !reset;
    assign spy_rvalid = rd_valid_q && (rd_sel_q == REQ_SPY) && !reset;
    assign cpu_rdata  = ram_q;
    assign spy_rdata  = ram_q;
    assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_pdl_ram_arbiter.sv
// Bench for pdl_ram_arbiter: RAM model, reference arbiter/memory model and read-return scoreboard.
module tb_pdl_ram_arbiter;

    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    logic        reset;
    logic        cpu_req, cpu_we, spy_req, spy_we;
    logic [9:0]  cpu_addr, spy_addr;
    logic [31:0] cpu_wdata, spy_wdata;
    logic        cpu_gnt, cpu_rvalid, spy_gnt, spy_rvalid, init_busy;
    logic [31:0] cpu_rdata, spy_rdata;
    logic [9:0]  ram_address;
    logic [31:0] ram_data, ram_q;
    logic        ram_wren, ram_rden;

    logic        b_reset;
    logic        b_cpu_req, b_cpu_we, b_spy_req, b_spy_we;
    logic [9:0]  b_cpu_addr, b_spy_addr;
    logic [31:0] b_cpu_wdata, b_spy_wdata;
    logic        b_cpu_gnt, b_cpu_rvalid, b_spy_gnt, b_spy_rvalid, b_init_busy;
    logic [31:0] b_cpu_rdata, b_spy_rdata;
    logic [9:0]  b_ram_address;
    logic [31:0] b_ram_data, b_ram_q;
    logic        b_ram_wren, b_ram_rden;

    pdl_ram_arbiter #(.STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1)) dut (
        .clk_a(clk_a), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .spy_req(spy_req), .spy_we(spy_we), .spy_addr(spy_addr), .spy_wdata(spy_wdata),
        .spy_gnt(spy_gnt), .spy_rvalid(spy_rvalid), .spy_rdata(spy_rdata),
        .init_busy(init_busy), .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
    );

    pdl_ram_arbiter #(.STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(0)) dut_b (
        .clk_a(clk_a), .reset(b_reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .spy_req(b_spy_req), .spy_we(b_spy_we), .spy_addr(b_spy_addr), .spy_wdata(b_spy_wdata),
        .spy_gnt(b_spy_gnt), .spy_rvalid(b_spy_rvalid), .spy_rdata(b_spy_rdata),
        .init_busy(b_init_busy), .ram_address(b_ram_address), .ram_data(b_ram_data),
        .ram_wren(b_ram_wren), .ram_rden(b_ram_rden), .ram_q(b_ram_q)
    );

    // ---------------- RAM models (registered read, like the real macro) ----------------
    logic [31:0] ram_a [0:1023];
    always @(posedge clk_a) begin
        if (ram_wren) ram_a[ram_address] <= ram_data;
        if (ram_rden) ram_q <= ram_a[ram_address];
    end

    function automatic logic [31:0] pat(input logic [9:0] a);
        return {6'h29, a, 6'h15, a};
    endfunction

    always @(posedge clk_a) begin
        if (b_ram_rden) b_ram_q <= pat(b_ram_address);
    end

    // ---------------- counters and check helper ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk_a) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [0:1023];
    bit          run_mode = 1'b0;
    int          m_wait   = 0;
    int          n_cpu_win = 0;
    int          n_spy_win = 0;
    logic [32:0] exp_q[$];      // {is_spy, data}
    int          due_q[$];

    always @(negedge clk_a) begin
        if (run_mode) begin
            bit          ec, es, we;
            logic [9:0]  a;
            logic [31:0] d;
            ec = cpu_req && !(spy_req && m_wait == LIMIT);
            es = spy_req && !ec;
            check("cpu_gnt", 32'(cpu_gnt), 32'(ec));
            check("spy_gnt", 32'(spy_gnt), 32'(es));
            check("init_busy_run", 32'(init_busy), 32'd0);
            if (ec || es) begin
                we = ec ? cpu_we : spy_we;
                a  = ec ? cpu_addr : spy_addr;
                d  = ec ? cpu_wdata : spy_wdata;
                check("ram_wren", 32'(ram_wren), 32'(we));
                check("ram_rden", 32'(ram_rden), 32'(!we));
                check("ram_address", 32'(ram_address), 32'(a));
                if (we) begin
                    check("ram_data", ram_data, d);
                    ref_mem[a] = d;
                end else begin
                    exp_q.push_back({es, ref_mem[a]});
                    due_q.push_back(cyc + 1);
                end
            end else begin
                check("ram_idle", 32'({ram_wren, ram_rden}), 32'd0);
            end
            if (ec) n_cpu_win++;
            if (es) n_spy_win++;
            m_wait = (spy_req && !es) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
        end
    end

    always @(negedge clk_a) begin
        logic [32:0] e;
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            n_cmp++;
            n_bad++;
            $display("FAIL rvalid_missing: expected read return not seen (cycle %0d)", cyc);
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            e = exp_q.pop_front();
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(!e[32]));
            check("spy_rvalid", 32'(spy_rvalid), 32'(e[32]));
            if (e[32]) check("spy_rdata", spy_rdata, e[31:0]);
            else       check("cpu_rdata", cpu_rdata, e[31:0]);
        end else begin
            check("no_rvalid", 32'({cpu_rvalid, spy_rvalid}), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_spy(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
        spy_req = r; spy_we = w; spy_addr = a; spy_wdata = d;
    endtask

    task automatic check_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_a);
            check("sweep_busy", 32'(init_busy), 32'd1);
            check("sweep_wren", 32'(ram_wren), 32'd1);
            check("sweep_rden", 32'(ram_rden), 32'd0);
            check("sweep_addr", 32'(ram_address), 32'(i));
            check("sweep_data", ram_data, 32'd0);
            check("sweep_no_gnt", 32'({cpu_gnt, spy_gnt}), 32'd0);
        end
    endtask

    task automatic enter_run();
        step();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        m_wait   = 0;
        run_mode = 1'b1;
    endtask

    task automatic random_phase(input int n);
        logic cg, sg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_a);
            cg = cpu_gnt;
            sg = spy_gnt;
            step();
            if (!cpu_req || cg)
                set_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        10'($urandom_range(0, 7)), $urandom);
            if (!spy_req || sg)
                set_spy(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        10'($urandom_range(0, 7)), $urandom);
        end
        set_cpu(0, 0, 0, 0);
        set_spy(0, 0, 0, 0);
        repeat (2) @(negedge clk_a);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r1, r2;
        logic [19:0] spy_pat;
        for (int i = 0; i < 1024; i++) ram_a[i] = $urandom;
        reset = 1'b1;
        b_reset = 1'b1;
        set_cpu(1, 1, 10'h3FF, 32'hDEADBEEF);
        set_spy(0, 0, 0, 0);
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_spy_req = 1; b_spy_we = 0; b_spy_addr = 10'h2A; b_spy_wdata = 0;

        repeat (2) @(negedge clk_a);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_ram_strobe", 32'({ram_wren, ram_rden}), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_rvalid", 32'({cpu_rvalid, spy_rvalid}), 32'd0);
        check("b_rst_spy_gnt", 32'(b_spy_gnt), 32'd0);
        check("b_rst_init_busy", 32'(b_init_busy), 32'd0);

        // Instance without sweep: SPY read granted on the first cycle out of reset.
        step();
        b_reset = 1'b0;
        @(negedge clk_a);
        check("b_init_busy", 32'(b_init_busy), 32'd0);
        check("b_spy_gnt", 32'(b_spy_gnt), 32'd1);
        check("b_ram_rden", 32'(b_ram_rden), 32'd1);
        check("b_ram_address", 32'(b_ram_address), 32'h2A);
        step();
        b_spy_req = 1'b0;
        @(negedge clk_a);
        check("b_spy_rvalid", 32'(b_spy_rvalid), 32'd1);
        check("b_spy_rdata", b_spy_rdata, pat(10'h2A));
        check("b_cpu_rvalid", 32'(b_cpu_rvalid), 32'd0);

        // Sweep with CPU request held throughout.
        step();
        reset = 1'b0;
        check_sweep(1024);
        enter_run();
        @(negedge clk_a);
        check("first_run_busy", 32'(init_busy), 32'd0);
        check("first_run_gnt", 32'(cpu_gnt), 32'd1);

        // CPU write then read of the top word.
        step();
        set_cpu(1, 0, 10'h3FF, 32'd0);
        @(negedge clk_a);
        check("rd_3ff_gnt", 32'(cpu_gnt), 32'd1);
        step();
        set_cpu(0, 0, 0, 0);
        @(negedge clk_a);
        check("rd_3ff_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_3ff_data", cpu_rdata, 32'hDEADBEEF);
        check("rd_3ff_spy_rvalid", 32'(spy_rvalid), 32'd0);

        // Sustained contention: CPU x4, SPY x1, repeating.
        step();
        n_cpu_win = 0;
        n_spy_win = 0;
        set_cpu(1, 0, 10'd1, 32'd0);
        set_spy(1, 0, 10'd2, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_a);
            spy_pat[i] = spy_gnt;
        end
        step();
        set_cpu(0, 0, 0, 0);
        set_spy(0, 0, 0, 0);
        check("contend_pattern", 32'(spy_pat), 32'h84210);
        check("contend_cpu_wins", 32'(n_cpu_win), 32'd16);
        check("contend_spy_wins", 32'(n_spy_win), 32'd4);

        // Alternating CPU/SPY reads with no bubbles.
        r1 = $urandom;
        r2 = $urandom;
        set_cpu(1, 1, 10'd5, r1);
        @(negedge clk_a);
        step();
        set_cpu(0, 0, 0, 0);
        set_spy(1, 1, 10'd6, r2);
        @(negedge clk_a);
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 0) begin
                set_cpu(1, 0, 10'd5, 0);
                set_spy(0, 0, 0, 0);
            end else begin
                set_cpu(0, 0, 0, 0);
                set_spy(1, 0, 10'd6, 0);
            end
            @(negedge clk_a);
            if (k > 0) begin
                check("alt_cpu_rvalid", 32'(cpu_rvalid), 32'(k % 2 == 1));
                check("alt_spy_rvalid", 32'(spy_rvalid), 32'(k % 2 == 0));
                check("alt_rdata", (k % 2 == 1) ? cpu_rdata : spy_rdata, (k % 2 == 1) ? r1 : r2);
            end
        end
        step();
        set_cpu(0, 0, 0, 0);
        set_spy(0, 0, 0, 0);
        @(negedge clk_a);
        check("alt_last_spy_rvalid", 32'(spy_rvalid), 32'd1);
        check("alt_last_rdata", spy_rdata, r2);

        random_phase(300);

        // Reset right after a CPU read grant: the return must be dropped.
        step();
        set_cpu(1, 0, 10'd5, 0);
        @(negedge clk_a);
        check("pre_reset_gnt", 32'(cpu_gnt), 32'd1);
        step();
        reset = 1'b1;
        set_cpu(0, 0, 0, 0);
        run_mode = 1'b0;
        exp_q.delete();
        due_q.delete();
        @(negedge clk_a);
        check("mid_rst_rvalid_0", 32'(cpu_rvalid), 32'd0);
        @(negedge clk_a);
        check("mid_rst_rvalid_1", 32'(cpu_rvalid), 32'd0);
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        step();
        reset = 1'b0;
        check_sweep(100);

        // Reset part-way through the sweep: it starts over at address 0.
        step();
        reset = 1'b1;
        @(negedge clk_a);
        check("rst_in_sweep_wren", 32'(ram_wren), 32'd0);
        step();
        reset = 1'b0;
        check_sweep(1024);
        enter_run();
        random_phase(200);

        step();
        check("exp_q_drained", 32'(due_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
